pixel_tile_counter: RTL and testbench
=====================================

PIXEL_TILE_COUNTER -- requirements
Module: pixel_tile_counter

Interface
REQ-001 SHALL have parameter MAX_W, default 1920, maximum active pixels per line.
REQ-002 SHALL have parameter MAX_H, default 1080, maximum active lines per frame.
REQ-003 SHALL have parameter PANEL_W, default 16, LED panel width in pixels.
REQ-004 SHALL have parameter PANEL_H, default 8, LED panel height in lines.
REQ-005 SHALL have parameter PPB, default 1, pixels per accepted beat; power of two; PANEL_W a multiple of PPB.
REQ-006 SHALL have parameter LOCK_FRAMES, default 2, identical consecutive measurements required for lock.
REQ-007 SHALL define WW = clog2(MAX_W)+1 and HW = clog2(MAX_H)+1.
REQ-008 clk  in  1  clock; all logic is rising-edge.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 vsync, hsync, de  in  1 each  video timing, active-high, synchronous to clk.
REQ-011 beat_valid  in  1  one pulse per PPB pixels consumed downstream.
REQ-012 col  out  WW, row  out  HW  pixel position of the next beat.
REQ-013 panel_x  out  WW, panel_y  out  HW  panel tile indices (col/PANEL_W, row/PANEL_H).
REQ-014 end_of_row, end_of_panel, end_of_band, end_of_frame  out  1 each  event pulses.
REQ-015 meas_width  out  WW, meas_height  out  HW  resolution of the last complete frame.
REQ-016 res_locked  out  1  level; res_changed  out  1  one-cycle pulse.

Function
REQ-017 SHALL register vsync/hsync once; vsync_rise = vsync & ~vsync_q, hsync_rise = hsync & ~hsync_q.
REQ-018 SHALL count de cycles into line_cnt; on hsync_rise with line_cnt != 0: line_w <= line_cnt, line_cnt <= 0, frame_lines += 1; de in the same cycle is lost.
REQ-019 line_cnt and frame_lines SHALL saturate at MAX_W and MAX_H.
REQ-020 On vsync_rise with frame_lines != 0: meas_width <= line_w, meas_height <= frame_lines; line_cnt, frame_lines cleared; frame_lines == 0 leaves meas_* unchanged.
REQ-021 Lock: a stable counter SHALL increment (saturating at LOCK_FRAMES) when a latched pair equals the previous pair, reset to 0 otherwise; res_locked = (stable == LOCK_FRAMES).
REQ-022 res_changed SHALL pulse one cycle after a latch whose pair differs from the previous nonzero pair.
REQ-023 col SHALL advance by PPB per beat_valid; end_of_row = beat_valid & (meas_width != 0) & (col + PPB >= meas_width); then col <= 0, row += 1.
REQ-024 With meas_width == 0, end_of_row SHALL stay low and col SHALL wrap to 0 on reaching MAX_W.
REQ-025 row SHALL saturate at MAX_H-1; end_of_row still pulses.
REQ-026 end_of_panel = beat_valid & ((col mod PANEL_W) + PPB == PANEL_W | end_of_row); panel_x += 1 on it, 0 on end_of_row.
REQ-027 end_of_band = end_of_row & (row mod PANEL_H == PANEL_H-1); panel_y += 1 on it.
REQ-028 Sub-counters SHALL replace division; no divider inferred.
REQ-029 end_of_frame = vsync_rise (combinational, same cycle).
REQ-030 vsync_rise SHALL clear col, row, panel_x, panel_y; a simultaneous beat_valid is not counted and generates no end_of_* pulse.
REQ-031 Event outputs SHALL be combinational from registered state and inputs; counters update next edge.

Reset
REQ-032 rst SHALL clear all registers, counters, meas_width, meas_height, res_locked, res_changed, stable to 0 immediately.
REQ-033 Reset mid-line or mid-frame SHALL discard partial measurements; first latch after reset SHALL not raise res_changed.

Verification
REQ-034 64x16 frames, PPB=1, 3 frames -> meas 64/16 after frame 1, res_locked after frame 3, res_changed never.
REQ-035 64x16 locked then 32x8 frame -> res_changed one pulse, res_locked drops, end_of_row on col 31.
REQ-036 PPB=4, width 64: 16 beats/row, end_of_panel every 4 beats, end_of_band on row 7 and 15.
REQ-037 beat_valid in same cycle as vsync_rise -> col/row 0, no end_of_row, end_of_frame high.
REQ-038 rst mid-frame at row 5 -> all outputs 0; next full frame latches without res_changed.
REQ-039 No vsync before beats, meas_width 0: 1920 beats -> col wraps to 0, end_of_row never.

Source files
------------

// File: rtl/pixel_tile_counter_if.sv
// Video timing inputs and tile-position/measurement outputs of pixel_tile_counter.
// beat_valid has no ready: each cycle it is high the consumer has taken PPB pixels.
interface pixel_tile_counter_if #(
    parameter int WW = 12,
    parameter int HW = 12
);
    logic          vsync;
    logic          hsync;
    logic          de;
    logic          beat_valid;
    logic [WW-1:0] col;
    logic [HW-1:0] row;
    logic [WW-1:0] panel_x;
    logic [HW-1:0] panel_y;
    logic          end_of_row;
    logic          end_of_panel;
    logic          end_of_band;
    logic          end_of_frame;
    logic [WW-1:0] meas_width;
    logic [HW-1:0] meas_height;
    logic          res_locked;
    logic          res_changed;

    modport master (
        output vsync, hsync, de, beat_valid,
        input  col, row, panel_x, panel_y,
        input  end_of_row, end_of_panel, end_of_band, end_of_frame,
        input  meas_width, meas_height, res_locked, res_changed
    );

    modport slave (
        input  vsync, hsync, de, beat_valid,
        output col, row, panel_x, panel_y,
        output end_of_row, end_of_panel, end_of_band, end_of_frame,
        output meas_width, meas_height, res_locked, res_changed
    );
endinterface

// File: rtl/pixel_tile_counter.sv
// Measures incoming video resolution and tracks the downstream beat position
// as pixel coordinates and LED panel tile indices, using sub-counters instead of dividers.
module pixel_tile_counter #(
    parameter int MAX_W       = 1920,
    parameter int MAX_H       = 1080,
    parameter int PANEL_W     = 16,
    parameter int PANEL_H     = 8,
    parameter int PPB         = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           clk,
    input  logic           rst,
    pixel_tile_counter_if.slave bus
);
    localparam int WW  = $clog2(MAX_W) + 1;
    localparam int HW  = $clog2(MAX_H) + 1;
    localparam int PXW = $clog2(PANEL_W) + 1;
    localparam int PYW = $clog2(PANEL_H) + 1;
    localparam int SW  = $clog2(LOCK_FRAMES + 1);

    localparam logic [WW-1:0]  MAX_W_V    = WW'(MAX_W);
    localparam logic [HW-1:0]  MAX_H_V    = HW'(MAX_H);
    localparam logic [HW-1:0]  ROW_LAST_V = HW'(MAX_H - 1);
    localparam logic [WW:0]    PPB_COL    = (WW + 1)'(PPB);
    localparam logic [WW:0]    MAX_W_EXT  = (WW + 1)'(MAX_W);
    localparam logic [PXW-1:0] PPB_SUB    = PXW'(PPB);
    localparam logic [PXW-1:0] PANEL_W_V  = PXW'(PANEL_W);
    localparam logic [PYW-1:0] SUB_Y_LAST = PYW'(PANEL_H - 1);
    localparam logic [SW-1:0]  LOCK_V     = SW'(LOCK_FRAMES);

    // Edge detection
    logic vsync_q;
    logic hsync_q;
    logic vsync_rise;
    logic hsync_rise;

    // Resolution measurement
    logic [WW-1:0] line_cnt;
    logic [WW-1:0] line_w;
    logic [HW-1:0] frame_lines;
    logic [WW-1:0] meas_width;
    logic [HW-1:0] meas_height;
    logic [SW-1:0] stable;
    logic          res_changed;
    logic          latch;
    logic          same_pair;
    logic          prev_nonzero;

    // Beat position
    logic [WW-1:0]  col;
    logic [HW-1:0]  row;
    logic [WW-1:0]  panel_x;
    logic [HW-1:0]  panel_y;
    logic [PXW-1:0] sub_x;
    logic [PYW-1:0] sub_y;
    logic [WW:0]    col_adv;
    logic [PXW-1:0] sub_x_adv;
    logic           beat;
    logic           row_last;
    logic           panel_last;
    logic           wrap;
    logic           row_sat;
    logic           eor;
    logic           eop;
    logic           eob;

    always_comb begin
        vsync_rise   = bus.vsync & ~vsync_q;
        hsync_rise   = bus.hsync & ~hsync_q;
        latch        = vsync_rise & (frame_lines != '0);
        same_pair    = (line_w == meas_width) & (frame_lines == meas_height);
        prev_nonzero = (meas_width != '0) | (meas_height != '0);
    end

    // A beat coinciding with the start of a frame belongs to no position.
    always_comb begin
        beat       = bus.beat_valid & ~vsync_rise;
        col_adv    = {1'b0, col} + PPB_COL;
        sub_x_adv  = sub_x + PPB_SUB;
        row_last   = (meas_width != '0) & (col_adv >= {1'b0, meas_width});
        panel_last = (sub_x_adv == PANEL_W_V);
        wrap       = (meas_width == '0) & (col_adv >= MAX_W_EXT);
        row_sat    = (row == ROW_LAST_V);
        eor        = beat & row_last;
        eop        = beat & (panel_last | row_last);
        eob        = eor & (sub_y == SUB_Y_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            line_cnt    <= '0;
            line_w      <= '0;
            frame_lines <= '0;
            meas_width  <= '0;
            meas_height <= '0;
            stable      <= '0;
            res_changed <= 1'b0;
        end else begin
            vsync_q     <= bus.vsync;
            hsync_q     <= bus.hsync;
            res_changed <= 1'b0;
            if (vsync_rise) begin
                line_cnt    <= '0;
                frame_lines <= '0;
                if (latch) begin
                    meas_width  <= line_w;
                    meas_height <= frame_lines;
                    // The all-zero pair after reset is not a real resolution.
                    res_changed <= prev_nonzero & ~same_pair;
                    if (same_pair) begin
                        if (stable != LOCK_V) begin
                            stable <= stable + 1'b1;
                        end
                    end else begin
                        stable <= '0;
                    end
                end
            end else if (hsync_rise) begin
                line_cnt <= '0;
                if (line_cnt != '0) begin
                    line_w <= line_cnt;
                    if (frame_lines != MAX_H_V) begin
                        frame_lines <= frame_lines + 1'b1;
                    end
                end
            end else if (bus.de && (line_cnt != MAX_W_V)) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            panel_x <= '0;
            panel_y <= '0;
            sub_x   <= '0;
            sub_y   <= '0;
        end else if (vsync_rise) begin
            col     <= '0;
            row     <= '0;
            panel_x <= '0;
            panel_y <= '0;
            sub_x   <= '0;
            sub_y   <= '0;
        end else if (beat) begin
            if (eor) begin
                col     <= '0;
                sub_x   <= '0;
                panel_x <= '0;
                // Once row saturates the band tracking freezes with it.
                if (!row_sat) begin
                    row <= row + 1'b1;
                    if (sub_y == SUB_Y_LAST) begin
                        sub_y   <= '0;
                        panel_y <= panel_y + 1'b1;
                    end else begin
                        sub_y <= sub_y + 1'b1;
                    end
                end
            end else if (wrap) begin
                col     <= '0;
                sub_x   <= '0;
                panel_x <= '0;
            end else begin
                col <= col_adv[WW-1:0];
                if (panel_last) begin
                    sub_x   <= '0;
                    panel_x <= panel_x + 1'b1;
                end else begin
                    sub_x <= sub_x_adv;
                end
            end
        end
    end

    assign bus.col          = col;
    assign bus.row          = row;
    assign bus.panel_x      = panel_x;
    assign bus.panel_y      = panel_y;
    assign bus.end_of_row   = eor;
    assign bus.end_of_panel = eop;
    assign bus.end_of_band  = eob;
    assign bus.end_of_frame = vsync_rise;
    assign bus.meas_width   = meas_width;
    assign bus.meas_height  = meas_height;
    assign bus.res_locked   = (stable == LOCK_V);
    assign bus.res_changed  = res_changed;
endmodule

// File: tb/tb_pixel_tile_counter.sv
// Directed bench for pixel_tile_counter: one PPB=1 and one PPB=4 instance share
// the video timing; each task drives a scenario and checks inline.
module tb_pixel_tile_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0;
  logic hsync = 1'b0;
  logic de = 1'b0;
  logic bv1 = 1'b0;
  logic bv4 = 1'b0;
  int pass_cnt = 0;
  int check_cnt = 0;
  int chg_cnt = 0;

  always #5 clk = ~clk;

  pixel_tile_counter_if #(.WW(12), .HW(12)) if1 ();
  pixel_tile_counter_if #(.WW(12), .HW(12)) if4 ();

  assign if1.vsync = vsync;
  assign if1.hsync = hsync;
  assign if1.de = de;
  assign if1.beat_valid = bv1;
  assign if4.vsync = vsync;
  assign if4.hsync = hsync;
  assign if4.de = de;
  assign if4.beat_valid = bv4;

  pixel_tile_counter #(.PPB(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  pixel_tile_counter #(.PPB(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  // Observed res_changed cycles on the PPB=1 instance.
  always @(negedge clk) if (if1.res_changed === 1'b1) chg_cnt++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int w);
    de = 1'b1;
    repeat (w) cyc();
    de = 1'b0;
    cyc();
    hsync = 1'b1;
    cyc();
    hsync = 1'b0;
    cyc();
  endtask

  task automatic send_frame(input int w, input int h);
    repeat (h) send_line(w);
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    check_cnt++; if (if1.col !== 12'd0) $display("FAIL reset_col: got %0d want 0", if1.col); else pass_cnt++;
    check_cnt++; if (if1.row !== 12'd0) $display("FAIL reset_row: got %0d want 0", if1.row); else pass_cnt++;
    check_cnt++; if (if1.panel_x !== 12'd0 || if1.panel_y !== 12'd0) $display("FAIL reset_panel: got %0d/%0d want 0/0", if1.panel_x, if1.panel_y); else pass_cnt++;
    check_cnt++; if (if1.meas_width !== 12'd0 || if1.meas_height !== 12'd0) $display("FAIL reset_meas: got %0d/%0d want 0/0", if1.meas_width, if1.meas_height); else pass_cnt++;
    check_cnt++; if (if1.res_locked !== 1'b0 || if1.res_changed !== 1'b0) $display("FAIL reset_lock: got %b/%b want 0/0", if1.res_locked, if1.res_changed); else pass_cnt++;
    check_cnt++; if ({if1.end_of_row, if1.end_of_panel, if1.end_of_band, if1.end_of_frame} !== 4'b0000) $display("FAIL reset_events: got %b want 0000", {if1.end_of_row, if1.end_of_panel, if1.end_of_band, if1.end_of_frame}); else pass_cnt++;
    check_cnt++; if (if4.col !== 12'd0 || if4.meas_width !== 12'd0) $display("FAIL reset_ppb4: got %0d/%0d want 0/0", if4.col, if4.meas_width); else pass_cnt++;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_wrap();
    int eor_seen = 0;
    bv1 = 1'b1;
    for (int i = 0; i < 1920; i++) begin
      #1;
      if (if1.end_of_row === 1'b1) eor_seen++;
      if (i == 1919) begin
        check_cnt++; if (if1.col !== 12'd1919) $display("FAIL wrap_col_top: got %0d want 1919", if1.col); else pass_cnt++;
      end
      cyc();
    end
    bv1 = 1'b0;
    #1;
    check_cnt++; if (if1.col !== 12'd0 || if1.row !== 12'd0) $display("FAIL wrap_col_zero: got %0d/%0d want 0/0", if1.col, if1.row); else pass_cnt++;
    check_cnt++; if (eor_seen !== 0) $display("FAIL wrap_no_eor: got %0d want 0", eor_seen); else pass_cnt++;
  endtask

  task automatic test_lock();
    int base = chg_cnt;
    send_frame(64, 16);
    check_cnt++; if (if1.meas_width !== 12'd64 || if1.meas_height !== 12'd16) $display("FAIL lock_meas1: got %0d/%0d want 64/16", if1.meas_width, if1.meas_height); else pass_cnt++;
    check_cnt++; if (if1.res_locked !== 1'b0) $display("FAIL lock_after1: got %b want 0", if1.res_locked); else pass_cnt++;
    send_frame(64, 16);
    check_cnt++; if (if1.res_locked !== 1'b0) $display("FAIL lock_after2: got %b want 0", if1.res_locked); else pass_cnt++;
    send_frame(64, 16);
    check_cnt++; if (if1.res_locked !== 1'b1) $display("FAIL lock_after3: got %b want 1", if1.res_locked); else pass_cnt++;
    check_cnt++; if (chg_cnt - base !== 0) $display("FAIL lock_no_change: got %0d want 0", chg_cnt - base); else pass_cnt++;
  endtask

  task automatic test_change();
    int base = chg_cnt;
    send_frame(32, 8);
    check_cnt++; if (if1.meas_width !== 12'd32 || if1.meas_height !== 12'd8) $display("FAIL change_meas: got %0d/%0d want 32/8", if1.meas_width, if1.meas_height); else pass_cnt++;
    check_cnt++; if (chg_cnt - base !== 1) $display("FAIL change_pulse: got %0d want 1", chg_cnt - base); else pass_cnt++;
    check_cnt++; if (if1.res_locked !== 1'b0) $display("FAIL change_unlock: got %b want 0", if1.res_locked); else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      bv1 = 1'b1;
      #1;
      check_cnt++; if (if1.end_of_row !== (i == 31)) $display("FAIL change_eor beat %0d: got %b want %b", i, if1.end_of_row, (i == 31)); else pass_cnt++;
      if (i == 31) begin
        check_cnt++; if (if1.col !== 12'd31) $display("FAIL change_eor_col: got %0d want 31", if1.col); else pass_cnt++;
      end
      cyc();
    end
    bv1 = 1'b0;
    #1;
    check_cnt++; if (if1.col !== 12'd0 || if1.row !== 12'd1) $display("FAIL change_next_row: got %0d/%0d want 0/1", if1.col, if1.row); else pass_cnt++;
  endtask

  task automatic test_ppb4();
    logic e_eop, e_eor, e_eob;
    send_frame(64, 16);
    check_cnt++; if (if4.meas_width !== 12'd64) $display("FAIL ppb4_meas: got %0d want 64", if4.meas_width); else pass_cnt++;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 16; k++) begin
        bv4 = 1'b1;
        #1;
        e_eop = (k % 4 == 3);
        e_eor = (k == 15);
        e_eob = (k == 15) && (r % 8 == 7);
        check_cnt++; if (if4.end_of_panel !== e_eop) $display("FAIL ppb4_eop r%0d k%0d: got %b want %b", r, k, if4.end_of_panel, e_eop); else pass_cnt++;
        check_cnt++; if (if4.end_of_row !== e_eor) $display("FAIL ppb4_eor r%0d k%0d: got %b want %b", r, k, if4.end_of_row, e_eor); else pass_cnt++;
        check_cnt++; if (if4.end_of_band !== e_eob) $display("FAIL ppb4_eob r%0d k%0d: got %b want %b", r, k, if4.end_of_band, e_eob); else pass_cnt++;
        if (r == 0 && k == 5) begin
          check_cnt++; if (if4.col !== 12'd20 || if4.panel_x !== 12'd1) $display("FAIL ppb4_pos: got %0d/%0d want 20/1", if4.col, if4.panel_x); else pass_cnt++;
        end
        cyc();
      end
    end
    bv4 = 1'b0;
    #1;
    check_cnt++; if (if4.row !== 12'd16 || if4.panel_y !== 12'd2 || if4.col !== 12'd0) $display("FAIL ppb4_end: got row %0d py %0d col %0d want 16/2/0", if4.row, if4.panel_y, if4.col); else pass_cnt++;
  endtask

  task automatic test_vsync_beat();
    bv1 = 1'b1;
    repeat (127) cyc();
    check_cnt++; if (if1.col !== 12'd63 || if1.row !== 12'd1) $display("FAIL vb_pre: got %0d/%0d want 63/1", if1.col, if1.row); else pass_cnt++;
    vsync = 1'b1;
    #1;
    check_cnt++; if (if1.end_of_frame !== 1'b1) $display("FAIL vb_eof: got %b want 1", if1.end_of_frame); else pass_cnt++;
    check_cnt++; if (if1.end_of_row !== 1'b0 || if1.end_of_panel !== 1'b0) $display("FAIL vb_no_eor: got %b/%b want 0/0", if1.end_of_row, if1.end_of_panel); else pass_cnt++;
    cyc();
    vsync = 1'b0;
    bv1 = 1'b0;
    #1;
    check_cnt++; if (if1.col !== 12'd0 || if1.row !== 12'd0) $display("FAIL vb_clear: got %0d/%0d want 0/0", if1.col, if1.row); else pass_cnt++;
    check_cnt++; if (if1.meas_width !== 12'd64 || if1.meas_height !== 12'd16) $display("FAIL vb_meas_kept: got %0d/%0d want 64/16", if1.meas_width, if1.meas_height); else pass_cnt++;
    cyc();
  endtask

  task automatic test_reset_mid();
    int base;
    repeat (3) send_line(64);
    bv1 = 1'b1;
    repeat (320) cyc();
    bv1 = 1'b0;
    #1;
    check_cnt++; if (if1.row !== 12'd5 || if1.col !== 12'd0) $display("FAIL rm_pre: got %0d/%0d want 5/0", if1.row, if1.col); else pass_cnt++;
    rst = 1'b1;
    #1;
    check_cnt++; if (if1.row !== 12'd0 || if1.col !== 12'd0 || if1.panel_x !== 12'd0 || if1.panel_y !== 12'd0) $display("FAIL rm_pos: got %0d/%0d/%0d/%0d want 0", if1.row, if1.col, if1.panel_x, if1.panel_y); else pass_cnt++;
    check_cnt++; if (if1.meas_width !== 12'd0 || if1.meas_height !== 12'd0) $display("FAIL rm_meas: got %0d/%0d want 0/0", if1.meas_width, if1.meas_height); else pass_cnt++;
    check_cnt++; if (if1.res_locked !== 1'b0 || if1.res_changed !== 1'b0) $display("FAIL rm_lock: got %b/%b want 0/0", if1.res_locked, if1.res_changed); else pass_cnt++;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    base = chg_cnt;
    send_frame(64, 16);
    check_cnt++; if (if1.meas_width !== 12'd64 || if1.meas_height !== 12'd16) $display("FAIL rm_relatch: got %0d/%0d want 64/16", if1.meas_width, if1.meas_height); else pass_cnt++;
    check_cnt++; if (chg_cnt - base !== 0) $display("FAIL rm_no_change: got %0d want 0", chg_cnt - base); else pass_cnt++;
    check_cnt++; if (if1.res_locked !== 1'b0) $display("FAIL rm_unlocked: got %b want 0", if1.res_locked); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_lock();
    test_change();
    test_ppb4();
    test_vsync_beat();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
